imem_program_loader: RTL and testbench
======================================

// Module: imem_program_loader
// PURPOSE
//  Upstream stage of the single-cycle RISC-V core. Receives a program as a byte stream
//  (valid/ready), packs the bytes into 32-bit words and writes them into instruction memory.
//  Holds the core in reset until the image loads and its checksum matches. Releases the
//  core only on success. On any failure the core stays in reset and the error is sticky.
// PARAMETERS
//  DEPTH_WORDS  256  IMEM capacity in 32-bit words; a larger length header is an error
//  ADDR_W       32   width of imem_addr (byte address, word aligned)
//  TIMEOUT_CYC  0    max idle cycles between accepted bytes mid-image; 0 disables timeout
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous, active-high reset
//  s_valid      in   1       byte-stream valid
//  s_data       in   8       byte-stream data
//  s_ready      out  1       loader accepts a byte this cycle
//  imem_we      out  1       one-cycle IMEM write strobe
//  imem_addr    out  ADDR_W  IMEM byte address = word_index*4
//  imem_wdata   out  32      IMEM write data
//  core_rst_n   out  1       active-low reset to the core; 1 only in DONE
//  done         out  1       image loaded and checksum matched (sticky)
//  error        out  1       length, checksum or timeout failure (sticky)
// BEHAVIOUR
//  - Reset: state=HDR, all counters, imem_we, imem_addr, imem_wdata, done, error = 0.
//    core_rst_n=0 and s_ready=0 while rst is high. IMEM contents are not cleared.
//  - A byte is accepted on a clock edge where s_valid & s_ready. s_ready is 1 in HDR, DATA
//    and CSUM, and 0 in DONE and ERR. s_data is ignored when no byte is accepted.
//  - Stream format: 4-byte little-endian LEN (word count), then LEN words, each sent as
//    4 little-endian bytes, then 1 checksum byte. The checksum is the XOR of all data bytes;
//    header bytes are excluded.
//  - FSM HDR -> DATA | CSUM | ERR; DATA -> CSUM | ERR; CSUM -> DONE | ERR; DONE and ERR are
//    terminal until rst.
//  - HDR exit, on the 4th accepted header byte (full 32-bit compare):
//      LEN > DEPTH_WORDS -> ERR; LEN == 0 -> CSUM; otherwise -> DATA.
//  - DATA: bytes shift into a 4-byte packer. On the edge that accepts the 4th byte:
//      imem_we=1 for exactly the next cycle, imem_addr = word_idx<<2, imem_wdata = packed word.
//      word_idx then increments. After word LEN-1 is written -> CSUM.
//      Back-to-back bytes are legal, so consecutive strobes can be 4 cycles apart.
//  - CSUM, on the accepted byte: match -> DONE (done=1 and core_rst_n=1 from the next cycle);
//    mismatch -> ERR (error=1, core_rst_n stays 0).
//  - Timeout, TIMEOUT_CYC > 0 only:
//      The idle counter runs in DATA, in CSUM, and in HDR once at least 1 header byte is taken.
//      It clears on every accepted byte.
//      Reaching TIMEOUT_CYC idle cycles -> ERR.
//      In HDR before the first byte the loader waits indefinitely.
//  - In ERR, imem_we never asserts. Words already written stay in IMEM.
//  - rst asserted mid-load aborts immediately: outputs return to reset values and a fresh
//    header is expected.
//  - The word counter is $clog2(DEPTH_WORDS+1) bits wide; addresses never wrap because
//    LEN is bounded at HDR exit.
// STRUCTURE
//  - Package loader_pkg: FSM state encoding (HDR, DATA, CSUM, DONE, ERR), HDR_BYTES=4,
//    BYTES_PER_WORD=4.
//  - Sub-module byte_packer: 2-bit byte counter plus a little-endian 32-bit shift register;
//    emits word_valid with the packed word. It is shared by the HDR and DATA states and
//    cleared on every state change.
//  - The top level holds the FSM, word_idx, the XOR accumulator, the idle counter and the
//    registered IMEM outputs.
// TESTING
//  1. LEN=2, bytes 93 00 50 00 13 01 10 00, csum C1
//     -> imem_we pulses: addr 0 data 00500093; addr 4 data 00100113.
//     -> done=1, core_rst_n=1, s_ready=0.
//  2. Same stream with csum C0 -> error=1, core_rst_n=0, s_ready=0; both writes still occurred.
//  3. LEN=257 (DEPTH_WORDS=256) -> error=1 right after the 4th header byte; no imem_we ever.
//  4. LEN=0, csum 00 -> done=1, core_rst_n=1, zero imem_we pulses.
//  5. TIMEOUT_CYC=8:
//     - s_valid gap of 7 cycles mid-word -> load completes normally.
//     - gap of 8 cycles -> error=1.
//     - 100 idle cycles before the first byte -> no error.
//  6. rst pulsed after 5 bytes accepted -> all outputs at reset values; the full test-1
//     stream then loads and finishes with done=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the IMEM program loader.
// Contents:
//   state_e         loader FSM state encoding
//   HDR_BYTES       number of little-endian bytes in the length header
//   BYTES_PER_WORD  number of stream bytes packed into one IMEM word
package loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word packer shared by the header and data phases.
// Ports:
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-high reset
//   clear_i       restart packing at byte 0 (asserted on every loader state change)
//   byte_valid_i  a byte is presented and consumed this cycle
//   byte_i        byte data
//   word_valid_o  combinational: this byte completes a word
//   word_o        combinational: packed word, first byte in bits [7:0]
//   count_o       number of bytes already held for the current word
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o,
    output logic [1:0]  count_o
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q;
    // Only the first three bytes need storage; the fourth is taken straight from byte_i.
    logic [23:0] sr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q <= cnt_q + 2'd1;
            sr_q  <= {byte_i, sr_q[23:8]};
        end
    end

    assign word_valid_o = byte_valid_i && (cnt_q == LAST_IDX);
    assign word_o       = {byte_i, sr_q};
    assign count_o      = cnt_q;

endmodule

// File: rtl/imem_program_loader.sv
// Boot-time program loader in front of the single-cycle RISC-V core.
// Receives a byte stream: 4-byte LE word count, LEN words as LE bytes, then one
// XOR checksum byte over the data bytes. Writes each packed word to IMEM and
// releases the core from reset only when the whole image and checksum are good.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   s_valid/s_data/s_ready byte stream handshake
//   imem_we/addr/wdata     registered one-cycle IMEM write port (byte address)
//   core_rst_n             active-low core reset, high only after a good load
//   done, error            sticky status flags
module imem_program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic              error
);

    localparam int CW     = $clog2(DEPTH_WORDS + 1);
    localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [31:0] MAX_LEN = 32'(DEPTH_WORDS);

    state_e              state_q, state_d;
    logic [CW-1:0]       word_idx_q;
    logic [CW-1:0]       len_q;
    logic [7:0]          csum_q;
    logic [IDLE_W-1:0]   idle_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                done_q, error_q, core_rst_n_q;

    logic                accept;
    logic                pk_in, pk_clear, pk_valid;
    logic [31:0]         pk_word;
    logic [1:0]          pk_cnt;
    logic                idle_run, timeout, last_word;

    // s_ready is gated by rst so it is low for the whole reset pulse, not just after it.
    assign s_ready = !rst && (state_q == ST_HDR || state_q == ST_DATA || state_q == ST_CSUM);
    assign accept  = s_valid && s_ready;

    assign pk_in    = accept && (state_q == ST_HDR || state_q == ST_DATA);
    assign pk_clear = (state_d != state_q);

    byte_packer u_packer (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_in),
        .byte_i       (s_data),
        .word_valid_o (pk_valid),
        .word_o       (pk_word),
        .count_o      (pk_cnt)
    );

    // In HDR the idle timer only arms once a header byte is held, so the loader
    // can wait forever for the stream to start.
    assign idle_run  = (state_q == ST_DATA) || (state_q == ST_CSUM) ||
                       (state_q == ST_HDR && pk_cnt != 2'd0);
    assign timeout   = (TIMEOUT_CYC > 0) && idle_run && !accept && (idle_q == IDLE_LAST);
    assign last_word = (word_idx_q == (len_q - CW'(1)));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR: begin
                if (pk_valid) begin
                    if (pk_word > MAX_LEN)    state_d = ST_ERR;
                    else if (pk_word == '0)   state_d = ST_CSUM;
                    else                      state_d = ST_DATA;
                end else if (timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_DATA: begin
                if (pk_valid && last_word) state_d = ST_CSUM;
                else if (timeout)          state_d = ST_ERR;
            end
            ST_CSUM: begin
                if (accept)       state_d = (s_data == csum_q) ? ST_DONE : ST_ERR;
                else if (timeout) state_d = ST_ERR;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HDR;
            word_idx_q   <= '0;
            len_q        <= '0;
            csum_q       <= '0;
            idle_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            imem_we_q <= 1'b0;

            // LEN is range-checked before DATA, so truncation to CW bits is lossless when used.
            if (state_q == ST_HDR && pk_valid)
                len_q <= pk_word[CW-1:0];

            if (state_q == ST_DATA && pk_valid) begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= ADDR_W'(word_idx_q) << 2;
                imem_wdata_q <= pk_word;
                word_idx_q   <= word_idx_q + CW'(1);
            end

            if (state_q == ST_DATA && accept)
                csum_q <= csum_q ^ s_data;

            if (accept || !idle_run)
                idle_q <= '0;
            else if (TIMEOUT_CYC > 0)
                idle_q <= idle_q + IDLE_W'(1);

            done_q       <= (state_d == ST_DONE);
            error_q      <= (state_d == ST_ERR);
            core_rst_n_q <= (state_d == ST_DONE);
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign done       = done_q;
    assign error      = error_q;
    assign core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    int w0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    imem_program_loader #(
        .DEPTH_WORDS (256),
        .ADDR_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every IMEM write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write observed addr=%h data=%h expected no write",
                       imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", imem_addr, e.addr);
                check("wr_data", imem_wdata, e.data);
            end
        end
    end

    // All stimulus tasks start and end just after a falling edge.
    task automatic send_byte(input logic [7:0] b);
        check("s_ready_before_byte", {31'd0, s_ready}, 32'd1);
        s_valid = 1'b1;
        s_data  = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [31:0] len);
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        send_byte(len[23:16]);
        send_byte(len[31:24]);
    endtask

    task automatic send_word(input logic [31:0] w, input int idx);
        wr_t e;
        e.addr = 32'(idx) * 32'd4;
        e.data = w;
        exp_q.push_back(e);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
    endtask

    task automatic check_end(input string tag, input logic d, input logic e, input int nwr);
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_error"}, {31'd0, error}, {31'd0, e});
        check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, {31'd0, d});
        check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        check({tag, "_writes"}, 32'(writes_seen - w0), 32'(nwr));
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test1_stream(input logic [7:0] csum);
        send_hdr(32'd2);
        send_word(32'h00500093, 0);
        send_word(32'h00100113, 1);
        send_byte(csum);
        idle(2);
    endtask

    initial begin
        // Test 1: two-word image, good checksum.
        do_reset();
        w0 = writes_seen;
        test1_stream(8'hC1);
        check_end("t1", 1'b1, 1'b0, 2);
        idle(3);
        check("t1_done_sticky", {31'd0, done}, 32'd1);

        // Test 2: bad checksum, writes still happen.
        do_reset();
        w0 = writes_seen;
        test1_stream(8'hC0);
        check_end("t2", 1'b0, 1'b1, 2);

        // Test 3: length over capacity, error right after the header.
        do_reset();
        w0 = writes_seen;
        send_hdr(32'd257);
        check("t3_error_now", {31'd0, error}, 32'd1);
        idle(3);
        check_end("t3", 1'b0, 1'b1, 0);

        // Test 4: empty image.
        do_reset();
        w0 = writes_seen;
        send_hdr(32'd0);
        send_byte(8'h00);
        idle(2);
        check_end("t4", 1'b1, 1'b0, 0);

        // Test 5a: 7-cycle gap mid-word is tolerated.
        do_reset();
        w0 = writes_seen;
        send_hdr(32'd1);
        begin
            wr_t e;
            e.addr = 32'd0;
            e.data = 32'h11223344;
            exp_q.push_back(e);
        end
        send_byte(8'h44);
        send_byte(8'h33);
        idle(7);
        check("t5a_no_error_after_gap", {31'd0, error}, 32'd0);
        send_byte(8'h22);
        send_byte(8'h11);
        send_byte(8'h44);
        idle(2);
        check_end("t5a", 1'b1, 1'b0, 1);

        // Test 5b: 8-cycle gap times out.
        do_reset();
        w0 = writes_seen;
        send_hdr(32'd1);
        send_byte(8'h44);
        send_byte(8'h33);
        idle(8);
        check("t5b_error_at_timeout", {31'd0, error}, 32'd1);
        idle(2);
        check_end("t5b", 1'b0, 1'b1, 0);

        // Test 5c: long wait before the first byte is not a timeout.
        do_reset();
        w0 = writes_seen;
        idle(100);
        check("t5c_no_error_idle", {31'd0, error}, 32'd0);
        check("t5c_ready_idle", {31'd0, s_ready}, 32'd1);
        test1_stream(8'hC1);
        check_end("t5c", 1'b1, 1'b0, 2);

        // Test 6: reset after five bytes, then a full load.
        do_reset();
        send_hdr(32'd2);
        send_byte(8'h93);
        do_reset();
        w0 = writes_seen;
        test1_stream(8'hC1);
        check_end("t6", 1'b1, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
